// File: rtl/voq_sched_ctrl.sv
// VOQ bookkeeping and crossbar sequencing around an external matcher.
// Counts cells per (in,out) pair, requests, applies grants, holds the xbar.
module voq_sched_ctrl #(
  parameter int N           = 4,
  parameter int LOGN        = 2,
  parameter int CNTW        = 8,
  parameter int CELL_CYCLES = 4,
  parameter int TMO         = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_arr_valid,
  input  logic [LOGN-1:0] i_arr_in,
  input  logic [LOGN-1:0] i_arr_out,
  output logic [N*N-1:0]  o_req,
  output logic [N-1:0]    o_input_idle,
  output logic [N-1:0]    o_output_idle,
  input  logic            i_grant_valid,
  input  logic [N*N-1:0]  i_acc_grant,
  output logic [N*N-1:0]  o_xbar_cfg,
  output logic [N-1:0]    o_deq,
  output logic            o_drop,
  output logic            o_grant_err,
  output logic            o_busy
);

  localparam int XW = $clog2(CELL_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    TRANSFER,
    GAP
  } state_t;

  state_t          state, state_nx;
  logic [CNTW-1:0] cnt [N*N];
  logic [N*N-1:0]  nz;
  logic [N*N-1:0]  eff;
  logic [N*N-1:0]  inc_v;
  logic [N*N-1:0]  dec_v;
  logic [N*N-1:0]  xbar_q;
  logic [N-1:0]    deq_q;
  logic [N-1:0]    deq_nx;
  logic            drop_q;
  logic            err_q;
  logic [3:0]      tmo_q;
  logic [XW-1:0]   xfer_q;
  logic            legal;
  logic            apply;
  logic            bad;
  logic            in_req;

  assign in_req = (state == REQUEST);
  assign apply  = in_req && i_grant_valid && legal;
  assign bad    = in_req && i_grant_valid && !legal;
  assign eff    = i_acc_grant & nz;
  assign dec_v  = apply ? eff : '0;

  always_comb begin
    nz    = '0;
    inc_v = '0;
    for (int k = 0; k < N*N; k++) begin
      nz[k]    = |cnt[k];
      inc_v[k] = i_arr_valid &&
                 ((int'(i_arr_in) * N + int'(i_arr_out)) == k);
    end
  end

  // Legal when no two grant bits share a row or a column.
  always_comb begin
    legal = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int a = 0; a < N; a++) begin
        for (int b = a + 1; b < N; b++) begin
          if (i_acc_grant[r*N+a] && i_acc_grant[r*N+b])
            legal = 1'b0;
          if (i_acc_grant[a*N+r] && i_acc_grant[b*N+r])
            legal = 1'b0;
        end
      end
    end
  end

  always_comb begin
    deq_nx = '0;
    for (int i = 0; i < N; i++)
      deq_nx[i] = |dec_v[i*N +: N];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N*N; k++)
        cnt[k] <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      for (int k = 0; k < N*N; k++) begin
        if (inc_v[k] && !dec_v[k]) begin
          if (&cnt[k])
            drop_q <= 1'b1;
          else
            cnt[k] <= cnt[k] + CNTW'(1);
        end else if (dec_v[k] && !inc_v[k]) begin
          cnt[k] <= cnt[k] - CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (|nz)
          state_nx = REQUEST;
      REQUEST:
        if (apply)
          state_nx = TRANSFER;
        else if (bad)
          state_nx = IDLE;
        else if (!i_grant_valid && tmo_q == 4'(TMO - 1))
          state_nx = IDLE;
      TRANSFER:
        if (xfer_q == XW'(CELL_CYCLES - 1))
          state_nx = GAP;
      GAP:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q  <= '0;
      xfer_q <= '0;
      xbar_q <= '0;
      deq_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      tmo_q  <= in_req ? tmo_q + 4'd1 : 4'd0;
      xfer_q <= (state == TRANSFER) ? xfer_q + XW'(1) : '0;
      deq_q  <= deq_nx;
      err_q  <= bad;
      if (apply)
        xbar_q <= eff;
    end
  end

  assign o_req         = in_req ? nz : '0;
  assign o_input_idle  = in_req ? '1 : '0;
  assign o_output_idle = in_req ? '1 : '0;
  assign o_xbar_cfg    = (state == TRANSFER) ? xbar_q : '0;
  assign o_deq         = deq_q;
  assign o_drop        = drop_q;
  assign o_grant_err   = err_q;
  assign o_busy        = (state != IDLE);

endmodule

// File: doc/voq_sched_ctrl.md
VOQ_SCHED_CTRL -- requirements
Module: voq_sched_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 4, number of ports; LOGN, default 2, port-index width; CNTW, default 8, per-VOQ counter width; CELL_CYCLES, default 4, crossbar hold time per cell in cycles; TMO, default 15, grant wait timeout in cycles (4-bit).
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- i_arr_valid  in  1  cell arrival strobe.
- i_arr_in  in  LOGN  arrival input port.
- i_arr_out  in  LOGN  arrival destination port.
- o_req  out  N*N  request matrix to the matching scheduler; bit in*N+out.
- o_input_idle  out  N  per-input idle to the scheduler.
- o_output_idle  out  N  per-output idle to the scheduler.
- i_grant_valid  in  1  scheduler result strobe.
- i_acc_grant  in  N*N  scheduler accepted-grant matrix; same bit layout as o_req.
- o_xbar_cfg  out  N*N  crossbar connection matrix.
- o_deq  out  N  per-input dequeue pulse.
- o_drop  out  1  arrival-dropped pulse.
- o_grant_err  out  1  illegal-grant pulse.
- o_busy  out  1  high outside IDLE.

Function
REQ-003 The block SHALL hold N*N VOQ counters of CNTW bits, indexed in*N+out.
REQ-004 On i_arr_valid, VOQ(i_arr_in,i_arr_out) SHALL increment by 1. When the counter is all-ones, the arrival SHALL be discarded and o_drop SHALL pulse for one cycle.
REQ-005 o_req[k] SHALL equal (count[k] != 0) while in REQUEST. o_req SHALL be 0 in every other state.
REQ-006 o_input_idle and o_output_idle SHALL be all-ones in REQUEST and all-zeros otherwise.
REQ-007 The FSM SHALL have the states IDLE, REQUEST, TRANSFER and GAP, with these transitions:
- IDLE->REQUEST when any count is nonzero; otherwise stay in IDLE.
- REQUEST->TRANSFER on a legal i_grant_valid.
- REQUEST->IDLE on an illegal grant.
- REQUEST->IDLE when TMO cycles pass without i_grant_valid.
- TRANSFER->GAP after exactly CELL_CYCLES cycles.
- GAP->IDLE after 1 cycle.
REQ-008 i_grant_valid SHALL be ignored outside REQUEST.
REQ-009 A grant SHALL be legal when no row and no column of i_acc_grant has more than one bit set.
REQ-010 On an illegal grant, o_grant_err SHALL pulse for one cycle and counters and o_xbar_cfg SHALL stay unchanged.
REQ-011 On a legal grant, the effective grant SHALL be i_acc_grant AND (count != 0). Granted bits for empty VOQs SHALL be silently masked.
REQ-012 In the cycle after a legal grant (first TRANSFER cycle):
- o_xbar_cfg SHALL equal the effective grant and SHALL hold for CELL_CYCLES cycles;
- each granted VOQ SHALL decrement by 1 once;
- o_deq[in] SHALL pulse for one cycle for each input with a granted bit.
REQ-013 o_xbar_cfg SHALL be 0 outside TRANSFER.
REQ-014 If an arrival and a decrement hit the same VOQ in the same cycle, the count SHALL be unchanged and o_drop SHALL NOT pulse.
REQ-015 An all-zero effective grant SHALL still enter TRANSFER, with o_xbar_cfg=0 and no o_deq.
REQ-016 The timeout counter SHALL clear on entry to REQUEST. The REQUEST->IDLE timeout transition SHALL raise no flags.
REQ-017 o_busy SHALL be 0 in IDLE and 1 in REQUEST, TRANSFER and GAP.
REQ-018 Arrivals SHALL be accepted in every state.

Reset
REQ-019 While reset is low, the block SHALL enter IDLE; all counters and timers SHALL clear; all outputs SHALL be 0.
REQ-020 Reset asserted mid-TRANSFER SHALL clear o_xbar_cfg asynchronously. Cells pending in the counters SHALL be lost.
REQ-021 After reset deasserts, the first rising edge SHALL be treated as IDLE.

Verification
REQ-022 Single arrival (in 1, out 2) -> REQUEST next cycle with o_req bit 6 set. Grant 0x0040 -> o_xbar_cfg=0x0040 for 4 cycles, o_deq=4'b0010 for one cycle, VOQ6 count 0, then GAP and IDLE.
REQ-023 256 arrivals to VOQ0 with no grants -> count 255 and o_drop pulses exactly once.
REQ-024 Row conflict: grant 0x0003 in REQUEST -> o_grant_err pulses, o_xbar_cfg stays 0, FSM returns to IDLE then REQUEST, counts unchanged.
REQ-025 No grant for 15 REQUEST cycles -> FSM returns to IDLE and re-enters REQUEST; o_req is 0 in the IDLE cycle.
REQ-026 VOQ5 count 1 with an arrival to VOQ5 in the grant-apply cycle -> count stays 1 and o_drop stays 0. Grant bit for an empty VOQ -> bit masked from o_xbar_cfg.
REQ-027 Reset pulled low in the 2nd TRANSFER cycle -> o_xbar_cfg, o_busy and all counts read 0 before the next clock edge.
